// File: rtl/ir_fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package : ir_fetch_sequencer_pkg
// Shared state encodings and the default address width for the
// instruction-register fetch sequencer.
// Revision: 1.0
// ============================================================================
package ir_fetch_sequencer_pkg;

    // Default program-memory address width, which is also the PC width.
    localparam int DEFAULT_AW = 8;

    // Raw 2-bit state codes. These are exported on the debug State port.
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FETCH_LO = 2'd1;
    localparam logic [1:0] ST_FETCH_HI = 2'd2;
    localparam logic [1:0] ST_HOLD     = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE     = ST_IDLE,
        S_FETCH_LO = ST_FETCH_LO,
        S_FETCH_HI = ST_FETCH_HI,
        S_HOLD     = ST_HOLD
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ir_fetch_sequencer_program_counter.sv
`default_nettype none
// ============================================================================
// Module  : ir_fetch_sequencer_program_counter
// AW-bit program counter. A load takes priority over an increment, and the
// counter wraps modulo 2^AW.
// Revision: 1.0
// ============================================================================
module ir_fetch_sequencer_program_counter
    import ir_fetch_sequencer_pkg::*;
#(
    parameter int AW = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [AW-1:0] load_value,
    input  logic          inc,
    output logic [AW-1:0] pc
);

    // PC register: a redirect wins over a fetch-beat increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + AW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ir_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : ir_fetch_sequencer
// Fetches 16-bit instructions as two byte beats (low byte, then high byte)
// from program memory. It steers the IR byte writes, owns the PC, and hands
// each completed instruction to the execute stage over a valid/ready pair.
// Revision: 1.0
// ============================================================================
module ir_fetch_sequencer
    import ir_fetch_sequencer_pkg::*;
#(
    parameter int AW = DEFAULT_AW
) (
    input  logic          Clock,
    input  logic          ResetN,
    input  logic          Enable,
    input  logic          PCLoad,
    input  logic [AW-1:0] PCIn,
    output logic [AW-1:0] MemAddr,
    output logic          MemRead,
    input  logic          MemReady,
    output logic          IRWrite,
    output logic          IRLH,
    output logic          InstrValid,
    input  logic          InstrReady,
    output logic [AW-1:0] InstrAddr,
    output logic [1:0]    State
);

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] pc;
    logic [AW-1:0] instr_addr_q;
    logic          fetching;
    logic          beat_taken;
    logic          lo_beat_taken;

    // A memory beat only counts when no redirect is happening in the same
    // cycle. A redirect discards any partially fetched instruction.
    assign fetching      = (state_q == S_FETCH_LO) || (state_q == S_FETCH_HI);
    assign beat_taken    = fetching && MemReady && !PCLoad;
    assign lo_beat_taken = (state_q == S_FETCH_LO) && MemReady && !PCLoad;

    ir_fetch_sequencer_program_counter #(
        .AW         (AW)
    ) u_pc (
        .clk        (Clock),
        .rst_n      (ResetN),
        .load       (PCLoad),
        .load_value (PCIn),
        .inc        (beat_taken),
        .pc         (pc)
    );

    // State register.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the address of each instruction's low byte as that byte is taken.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            instr_addr_q <= '0;
        end else if (lo_beat_taken) begin
            instr_addr_q <= pc;
        end
    end

    // Next-state decode. A redirect overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (PCLoad) begin
            state_d = Enable ? S_FETCH_LO : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Enable) state_d = S_FETCH_LO;
                end
                S_FETCH_LO: begin
                    if (MemReady) state_d = S_FETCH_HI;
                end
                S_FETCH_HI: begin
                    if (MemReady) state_d = S_HOLD;
                end
                S_HOLD: begin
                    if (InstrReady) state_d = Enable ? S_FETCH_LO : S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output decode. MemRead stays high across a redirect cycle because the
    // bus read is harmless; the IR write is what gets suppressed.
    always_comb begin
        MemRead    = fetching;
        IRLH       = (state_q == S_FETCH_HI);
        IRWrite    = beat_taken;
        InstrValid = (state_q == S_HOLD) && !PCLoad;
    end

    assign MemAddr   = pc;
    assign InstrAddr = instr_addr_q;
    assign State     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ir_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_ir_fetch_sequencer
// Directed self-checking bench for ir_fetch_sequencer. It models the program
// memory and the 16-bit IR that the sequencer controls.
// Revision: 1.0
// ============================================================================
module tb_ir_fetch_sequencer;

    logic       Clock;
    logic       ResetN;
    logic       Enable;
    logic       PCLoad;
    logic [7:0] PCIn;
    logic [7:0] MemAddr;
    logic       MemRead;
    logic       MemReady;
    logic       IRWrite;
    logic       IRLH;
    logic       InstrValid;
    logic       InstrReady;
    logic [7:0] InstrAddr;
    logic [1:0] State;

    logic [7:0]  mem [0:255];
    logic [15:0] ir_model;

    int vectors;
    int miscompares;

    ir_fetch_sequencer #(.AW(8)) dut (
        .Clock      (Clock),
        .ResetN     (ResetN),
        .Enable     (Enable),
        .PCLoad     (PCLoad),
        .PCIn       (PCIn),
        .MemAddr    (MemAddr),
        .MemRead    (MemRead),
        .MemReady   (MemReady),
        .IRWrite    (IRWrite),
        .IRLH       (IRLH),
        .InstrValid (InstrValid),
        .InstrReady (InstrReady),
        .InstrAddr  (InstrAddr),
        .State      (State)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // IR model: the memory returns data combinationally, and the IR captures
    // the addressed byte on a write.
    always @(posedge Clock) begin
        if (IRWrite) begin
            if (IRLH) ir_model[15:8] <= mem[MemAddr];
            else      ir_model[7:0]  <= mem[MemAddr];
        end
    end

    // Advance one clock edge and settle 1 time unit past it.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        ResetN = 1'b0;
        step();
        step();
        #1;
        vectors++; if (State !== 2'd0) begin miscompares++; $display("FAIL reset_state got=%0d exp=0", State); end
        vectors++; if (MemAddr !== 8'h00) begin miscompares++; $display("FAIL reset_memaddr got=%h exp=00", MemAddr); end
        vectors++; if (MemRead !== 1'b0) begin miscompares++; $display("FAIL reset_memread got=%b exp=0", MemRead); end
        vectors++; if (IRWrite !== 1'b0 || IRLH !== 1'b0) begin miscompares++; $display("FAIL reset_ir_ctl got=%b%b exp=00", IRWrite, IRLH); end
        vectors++; if (InstrValid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", InstrValid); end
        vectors++; if (InstrAddr !== 8'h00) begin miscompares++; $display("FAIL reset_instraddr got=%h exp=00", InstrAddr); end
        ResetN = 1'b1;
        step();
        vectors++; if (State !== 2'd0) begin miscompares++; $display("FAIL idle_no_enable got=%0d exp=0", State); end
    endtask

    // Two back-to-back instructions from address 0 with zero-wait memory.
    task automatic test_basic_fetch();
        Enable = 1'b1; MemReady = 1'b1; InstrReady = 1'b1;
        #1;
        vectors++; if (State !== 2'd0 || MemRead !== 1'b0) begin miscompares++; $display("FAIL basic_idle got st=%0d rd=%b exp st=0 rd=0", State, MemRead); end
        step();
        vectors++; if (State !== 2'd1 || MemRead !== 1'b1 || MemAddr !== 8'h00) begin miscompares++; $display("FAIL basic_lo got st=%0d rd=%b a=%h exp 1/1/00", State, MemRead, MemAddr); end
        vectors++; if (IRWrite !== 1'b1 || IRLH !== 1'b0) begin miscompares++; $display("FAIL basic_lo_ir got wr=%b lh=%b exp 1/0", IRWrite, IRLH); end
        step();
        vectors++; if (State !== 2'd2 || MemAddr !== 8'h01 || InstrAddr !== 8'h00) begin miscompares++; $display("FAIL basic_hi got st=%0d a=%h ia=%h exp 2/01/00", State, MemAddr, InstrAddr); end
        vectors++; if (IRWrite !== 1'b1 || IRLH !== 1'b1) begin miscompares++; $display("FAIL basic_hi_ir got wr=%b lh=%b exp 1/1", IRWrite, IRLH); end
        step();
        vectors++; if (State !== 2'd3 || InstrValid !== 1'b1 || MemRead !== 1'b0 || IRWrite !== 1'b0) begin miscompares++; $display("FAIL basic_hold got st=%0d v=%b rd=%b wr=%b exp 3/1/0/0", State, InstrValid, MemRead, IRWrite); end
        vectors++; if (ir_model !== 16'h1234) begin miscompares++; $display("FAIL basic_ir1 got=%h exp=1234", ir_model); end
        vectors++; if (InstrAddr !== 8'h00 || MemAddr !== 8'h02) begin miscompares++; $display("FAIL basic_addr1 got ia=%h pc=%h exp 00/02", InstrAddr, MemAddr); end
        step();
        vectors++; if (State !== 2'd1 || MemAddr !== 8'h02 || InstrValid !== 1'b0) begin miscompares++; $display("FAIL basic_next_lo got st=%0d a=%h v=%b exp 1/02/0", State, MemAddr, InstrValid); end
        // Drop Enable mid-fetch; this instruction still completes and hands off.
        Enable = 1'b0;
        step();
        step();
        vectors++; if (State !== 2'd3 || ir_model !== 16'h5678 || InstrAddr !== 8'h02) begin miscompares++; $display("FAIL basic_ir2 got st=%0d ir=%h ia=%h exp 3/5678/02", State, ir_model, InstrAddr); end
        step();
        vectors++; if (State !== 2'd0 || MemAddr !== 8'h04) begin miscompares++; $display("FAIL basic_park got st=%0d pc=%h exp 0/04", State, MemAddr); end
    endtask

    // Memory stalls for 3 cycles while the high byte is outstanding.
    task automatic test_mem_wait();
        Enable = 1'b1; MemReady = 1'b1; InstrReady = 1'b0;
        step();
        step();
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (State !== 2'd2 || MemRead !== 1'b1 || IRWrite !== 1'b0 || MemAddr !== 8'h05) begin miscompares++; $display("FAIL wait_hi[%0d] got st=%0d rd=%b wr=%b a=%h exp 2/1/0/05", i, State, MemRead, IRWrite, MemAddr); end
            step();
        end
        MemReady = 1'b1;
        #1;
        vectors++; if (IRWrite !== 1'b1) begin miscompares++; $display("FAIL wait_release got wr=%b exp=1", IRWrite); end
        step();
        vectors++; if (State !== 2'd3 || MemAddr !== 8'h06 || ir_model !== 16'hBC9A) begin miscompares++; $display("FAIL wait_done got st=%0d pc=%h ir=%h exp 3/06/bc9a", State, MemAddr, ir_model); end
    endtask

    // Execute stage refuses the instruction for 4 cycles.
    task automatic test_hold_stall();
        InstrReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++; if (State !== 2'd3 || InstrValid !== 1'b1 || MemRead !== 1'b0 || MemAddr !== 8'h06) begin miscompares++; $display("FAIL stall[%0d] got st=%0d v=%b rd=%b pc=%h exp 3/1/0/06", i, State, InstrValid, MemRead, MemAddr); end
        end
        InstrReady = 1'b1;
        step();
        vectors++; if (State !== 2'd1 || InstrValid !== 1'b0 || MemAddr !== 8'h06) begin miscompares++; $display("FAIL stall_accept got st=%0d v=%b a=%h exp 1/0/06", State, InstrValid, MemAddr); end
    endtask

    // Branch during FETCH_HI, then a second branch racing InstrReady in HOLD.
    task automatic test_redirect();
        step();
        PCLoad = 1'b1; PCIn = 8'h80;
        #1;
        vectors++; if (State !== 2'd2 || IRWrite !== 1'b0) begin miscompares++; $display("FAIL redir_hi got st=%0d wr=%b exp 2/0", State, IRWrite); end
        step();
        PCLoad = 1'b0;
        #1;
        vectors++; if (State !== 2'd1 || MemAddr !== 8'h80) begin miscompares++; $display("FAIL redir_target got st=%0d a=%h exp 1/80", State, MemAddr); end
        step();
        vectors++; if (InstrAddr !== 8'h80 || MemAddr !== 8'h81) begin miscompares++; $display("FAIL redir_instraddr got ia=%h a=%h exp 80/81", InstrAddr, MemAddr); end
        step();
        vectors++; if (State !== 2'd3 || ir_model !== 16'h2211) begin miscompares++; $display("FAIL redir_ir got st=%0d ir=%h exp 3/2211", State, ir_model); end
        PCLoad = 1'b1; PCIn = 8'hFF;
        #1;
        vectors++; if (InstrValid !== 1'b0) begin miscompares++; $display("FAIL redir_hold_valid got=%b exp=0", InstrValid); end
        step();
        PCLoad = 1'b0;
        #1;
        vectors++; if (State !== 2'd1 || MemAddr !== 8'hFF) begin miscompares++; $display("FAIL redir_hold got st=%0d a=%h exp 1/ff", State, MemAddr); end
    endtask

    // An instruction straddling the wrap: low byte at FF, high byte at 00.
    task automatic test_wrap();
        step();
        vectors++; if (State !== 2'd2 || MemAddr !== 8'h00 || InstrAddr !== 8'hFF) begin miscompares++; $display("FAIL wrap_hi got st=%0d a=%h ia=%h exp 2/00/ff", State, MemAddr, InstrAddr); end
        Enable = 1'b0;
        step();
        vectors++; if (State !== 2'd3 || MemAddr !== 8'h01 || ir_model !== 16'h34EF || InstrAddr !== 8'hFF) begin miscompares++; $display("FAIL wrap_done got st=%0d pc=%h ir=%h ia=%h exp 3/01/34ef/ff", State, MemAddr, ir_model, InstrAddr); end
        step();
        vectors++; if (State !== 2'd0) begin miscompares++; $display("FAIL wrap_park got st=%0d exp=0", State); end
    endtask

    // Asynchronous reset asserted between clock edges during FETCH_HI.
    task automatic test_async_reset();
        Enable = 1'b1; MemReady = 1'b1;
        step();
        step();
        vectors++; if (State !== 2'd2) begin miscompares++; $display("FAIL areset_pre got st=%0d exp=2", State); end
        #1;
        ResetN = 1'b0;
        #1;
        vectors++; if (State !== 2'd0 || MemAddr !== 8'h00 || InstrAddr !== 8'h00) begin miscompares++; $display("FAIL areset_regs got st=%0d a=%h ia=%h exp 0/00/00", State, MemAddr, InstrAddr); end
        vectors++; if (MemRead !== 1'b0 || IRWrite !== 1'b0 || IRLH !== 1'b0 || InstrValid !== 1'b0) begin miscompares++; $display("FAIL areset_outs got rd=%b wr=%b lh=%b v=%b exp 0000", MemRead, IRWrite, IRLH, InstrValid); end
        Enable = 1'b0;
        #1;
        ResetN = 1'b1;
        step();
        step();
        vectors++; if (State !== 2'd0 || MemAddr !== 8'h00) begin miscompares++; $display("FAIL areset_idle got st=%0d a=%h exp 0/00", State, MemAddr); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        ResetN = 1'b0; Enable = 1'b0; PCLoad = 1'b0; PCIn = 8'h00;
        MemReady = 1'b0; InstrReady = 1'b0;
        ir_model = 16'h0000;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h34; mem[8'h01] = 8'h12;
        mem[8'h02] = 8'h78; mem[8'h03] = 8'h56;
        mem[8'h04] = 8'h9A; mem[8'h05] = 8'hBC;
        mem[8'h06] = 8'hDE; mem[8'h07] = 8'hF0;
        mem[8'h80] = 8'h11; mem[8'h81] = 8'h22;
        mem[8'hFF] = 8'hEF;

        test_reset();
        test_basic_fetch();
        test_mem_wait();
        test_hold_stall();
        test_redirect();
        test_wrap();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ir_fetch_sequencer.md
Name: ir_fetch_sequencer

Overview:
- Sequences the 16-bit instruction register. Fetches two consecutive bytes from 8-bit program memory, low byte first, and drives the IR write and half-select controls.
- Presents the completed instruction to the execute stage through a valid/ready handshake.
- Owns the program counter: increment on each fetched byte, redirect on branch load.
- Sits between program memory, the instruction register and the control unit.

Parameters:
AW, 8, program-memory address width; PC width; wraps modulo 2^AW.

Ports:
Clock  in  1  system clock, rising edge.
ResetN  in  1  asynchronous active-low reset.
Enable  in  1  run request; when low, sequencer parks in IDLE after the current handoff.
PCLoad  in  1  redirect request (branch/jump).
PCIn  in  AW  redirect target address.
MemAddr  out  AW  program-memory byte address (= PC).
MemRead  out  1  memory read strobe.
MemReady  in  1  memory data valid this cycle (combinational return into IR byte input).
IRWrite  out  1  IR write enable.
IRLH  out  1  IR half select: 0 = low byte, 1 = high byte.
InstrValid  out  1  IR holds a complete instruction.
InstrReady  in  1  execute stage accepts the instruction.
InstrAddr  out  AW  address of the low byte of the instruction in IR.
State  out  2  current state, for debug.

Behaviour:
- States: IDLE=0, FETCH_LO=1, FETCH_HI=2, HOLD=3.
- Reset (ResetN low, any time, asynchronous):
  - State=IDLE, PC=0, InstrAddr=0.
  - All outputs 0 (MemAddr=0).
  - Any fetch in progress is abandoned.
- IDLE:
  - MemRead=0, IRWrite=0.
  - Enable=1 -> FETCH_LO next cycle.
- FETCH_LO:
  - MemRead=1, MemAddr=PC, IRLH=0.
  - IRWrite = MemReady (combinational).
  - On a MemReady cycle: InstrAddr<=PC, PC<=PC+1, -> FETCH_HI.
  - MemReady=0: hold state, unbounded wait.
- FETCH_HI:
  - Same as FETCH_LO but IRLH=1, and InstrAddr is unchanged.
  - On a MemReady cycle: PC<=PC+1, -> HOLD.
- HOLD:
  - InstrValid=1, MemRead=0, IRWrite=0.
  - On an InstrReady cycle: -> FETCH_LO if Enable=1, else IDLE.
  - InstrValid falls the cycle after acceptance.
  - Throughput: 3 cycles per instruction with zero-wait memory and InstrReady held high.
- Enable deasserted mid-fetch: the current instruction completes through HOLD and handoff; then IDLE.
- PCLoad=1, any state except reset; highest priority:
  - PC<=PCIn.
  - IRWrite and InstrValid forced 0 that cycle.
  - Next state: FETCH_LO if Enable=1, else IDLE.
  - A partially fetched instruction is discarded.
  - A simultaneous InstrReady in HOLD is ignored (redirect wins).
- PC wrap: AW'h..FF + 1 -> 0.
  - An instruction may straddle the wrap: low byte at max address, high byte at 0.
- MemAddr always equals PC.
- IRWrite is asserted only in FETCH_LO/FETCH_HI with MemReady=1, so exactly one IR byte is written per accepted memory beat.

Decomposition:
- Shared package: state encodings (ST_IDLE, ST_FETCH_LO, ST_FETCH_HI, ST_HOLD) as 2-bit localparams; default AW.
- One natural sub-module, program_counter: AW-bit register with async active-low reset, load (priority) and increment inputs.
- FSM and output decode stay in ir_fetch_sequencer.

Test Plan:
- Reset then Enable=1, MemReady=1, InstrReady=1, memory[0]=8'h34, memory[1]=8'h12 -> IRWrite/IRLH pulses 0 then 1; IR=16'h1234; InstrValid in cycle 3; InstrAddr=0; PC=2; next fetch starts at address 2.
- MemReady low for 3 cycles in FETCH_HI -> state holds at 2, MemRead=1, IRWrite=0; completes on the first MemReady cycle; PC advances only once.
- InstrReady=0 for 4 cycles in HOLD -> InstrValid stays 1; MemRead=0; PC unchanged.
- PCLoad=1, PCIn=8'h80 during FETCH_HI -> no IR write that cycle; next MemAddr=8'h80 in FETCH_LO; InstrAddr=8'h80 after the low byte.
- PC=8'hFF at FETCH_LO -> bytes read from FF then 00; InstrAddr=FF; PC=01 afterwards.
- ResetN pulsed low mid-FETCH_HI without a clock edge -> State=0, PC=0, all outputs 0 immediately; Enable=0 afterwards keeps IDLE.
